vend_credit_fsm: RTL and testbench
==================================

Name: vend_credit_fsm

Overview:
- Consumer end of the front-panel button path: takes debounced button levels and turns them into vending transactions.
- Converts coin-button levels into single-cycle coin events and accumulates credit against a fixed price.
- Sequences dispense, change and refund outputs that drive board LEDs.
- Sits downstream of the debouncer instances, in the CLK50M domain.

Parameters:
- PRICE, 75, item price in cents; PRICE > 0 and PRICE + 24 <= 2^CREDIT_W - 1 (elaboration check).
- CREDIT_W, 8, width of the credit and change values.
- DISP_CYCLES, 50_000_000, number of cycles the dispense/refund indication is held (1 s at 50 MHz); must be >= 1.

Ports:
- CLK50M  in  1  board clock, 50 MHz
- RSTb  in  1  asynchronous, active-low reset
- nickel  in  1  debounced level, active-high, synchronous to CLK50M; worth 5
- dime  in  1  debounced level, active-high; worth 10
- quarter  in  1  debounced level, active-high; worth 25
- cancel  in  1  debounced level, active-high; requests a refund
- credit  out  CREDIT_W  credit accumulated in the current transaction
- dispense  out  1  high while the item is being dispensed
- change  out  CREDIT_W  change or refund amount; valid while busy
- busy  out  1  high in VEND or REFUND

Behaviour:
- Reset: RSTb low immediately forces state IDLE, credit=0, change=0, dispense=0, busy=0, hold counter=0.
  - All edge-history flops reset to 1, so a button held through reset release produces no event.
  - Reset asserted mid-transaction discards credit; there is no refund.
- Edge detection, per input: event = level & ~prev, where prev is the previous-cycle level.
  - One event per press, regardless of how long the button is held.
- Simultaneous events in one cycle:
  - cancel beats any coin.
  - Coins resolve by priority quarter > dime > nickel.
  - Lower-priority events are dropped, not queued.
- Latency: an event in cycle n is reflected on credit, state and outputs in cycle n+1.
- States: IDLE, COLLECT, VEND, REFUND.
- IDLE:
  - Coin of value v: if v >= PRICE, go to VEND with change = v - PRICE; otherwise credit = v and go to COLLECT.
  - cancel is ignored.
- COLLECT:
  - Coin: sum = credit + v. If sum >= PRICE, go to VEND with change = sum - PRICE and credit = 0. Otherwise credit = sum.
  - cancel: go to REFUND with change = credit and credit = 0.
  - No overflow is possible given the PRICE constraint; sum is computed at CREDIT_W+1 bits.
- VEND:
  - dispense=1, busy=1, change held constant.
  - Hold counter runs 0..DISP_CYCLES-1; dispense is high for exactly DISP_CYCLES cycles.
  - At the terminal count: go to IDLE with change=0 and dispense=0.
  - All coin and cancel events are ignored; coins inserted here are lost by design.
- REFUND:
  - Same hold timing as VEND, with dispense=0, busy=1 and change = refunded credit.
  - At the terminal count: go to IDLE with change=0.
- Counter width: $clog2(DISP_CYCLES+1). The counter is cleared on entry to VEND and to REFUND.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package vend_pkg:
  - state enum (IDLE, COLLECT, VEND, REFUND);
  - coin value constants NICKEL_C=5, DIME_C=10, QUARTER_C=25.
- Sub-module edge_pulse:
  - one-flop rising-edge detector with its history flop resetting to 1;
  - instantiated four times, one per button input.

Test Plan (PRICE=75, CREDIT_W=8, DISP_CYCLES=4):
- Exact price: quarter pressed three times, each press 3 cycles high -> credit 25, 50; then dispense=1 and busy=1 for exactly 4 cycles with change=0; credit returns to 0 and IDLE.
- Overpay: dime, then quarter three times -> credit 10, 35, 60; dispense for 4 cycles with change=10; change=0 after.
- Cancel: nickel, then cancel -> credit 5, then REFUND with change=5 and dispense=0 for 4 cycles; cancel pressed again in IDLE -> no response.
- Held and simultaneous inputs:
  - quarter held high for 20 cycles -> credit=25, exactly one event;
  - quarter and dime rising in the same cycle -> +25 only;
  - cancel and quarter rising together in COLLECT -> REFUND with the prior credit.
- Lockout and reset release: quarter pressed during VEND -> credit stays 0 after the return to IDLE; quarter held across RSTb release -> credit stays 0.
- Async reset: RSTb pulled low during VEND between clock edges -> dispense, busy, change and credit all 0 before the next CLK50M edge; after release, nickel -> credit=5.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and coin values for the vending credit controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } state_t;

  localparam int unsigned NICKEL_C  = 5;
  localparam int unsigned DIME_C    = 10;
  localparam int unsigned QUARTER_C = 25;

  // Value of the winning coin event; quarter beats dime beats nickel, losers are dropped.
  function automatic int unsigned coin_value(input logic q, input logic d, input logic n);
    int unsigned v;
    v = 0;
    if (q)      v = QUARTER_C;
    else if (d) v = DIME_C;
    else if (n) v = NICKEL_C;
    return v;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for one debounced button level.
// History flop resets high so a button held across reset release yields no event.
module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse_c
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= level;
  end

  assign pulse_c = level & ~prev;

endmodule

// File: rtl/vend_credit_fsm.sv
// Vending transaction controller: coin events accumulate credit, then a timed
// dispense or refund indication is held with the change/refund amount.
module vend_credit_fsm
  import vend_pkg::*;
#(
  parameter int unsigned PRICE       = 75,
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned DISP_CYCLES = 50_000_000
) (
  input  logic                CLK50M,
  input  logic                RSTb,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic [CREDIT_W-1:0] change,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(DISP_CYCLES + 1);
  localparam int unsigned SUM_W = CREDIT_W + 1;

  if (!((PRICE > 0) && (PRICE + 24 <= (2 ** CREDIT_W) - 1) && (DISP_CYCLES >= 1))) begin : g_param_check
    $error("vend_credit_fsm: PRICE/CREDIT_W/DISP_CYCLES out of range");
  end

  logic nickel_ev, dime_ev, quarter_ev, cancel_ev;

  edge_pulse u_edge_nickel  (.clk(CLK50M), .rst_n(RSTb), .level(nickel),  .pulse_c(nickel_ev));
  edge_pulse u_edge_dime    (.clk(CLK50M), .rst_n(RSTb), .level(dime),    .pulse_c(dime_ev));
  edge_pulse u_edge_quarter (.clk(CLK50M), .rst_n(RSTb), .level(quarter), .pulse_c(quarter_ev));
  edge_pulse u_edge_cancel  (.clk(CLK50M), .rst_n(RSTb), .level(cancel),  .pulse_c(cancel_ev));

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  logic                coin_ev_c;
  logic [CREDIT_W-1:0] coin_val_c;
  logic [SUM_W-1:0]    sum_c;
  logic                paid_c;
  logic [CREDIT_W-1:0] over_c;
  logic                hold_done_c;

  // Coin resolution and the running-sum arithmetic (one bit wider than credit).
  always_comb begin
    coin_ev_c   = quarter_ev | dime_ev | nickel_ev;
    coin_val_c  = CREDIT_W'(coin_value(quarter_ev, dime_ev, nickel_ev));
    sum_c       = SUM_W'(credit) + SUM_W'(coin_val_c);
    paid_c      = (sum_c >= SUM_W'(PRICE));
    over_c      = CREDIT_W'(sum_c - SUM_W'(PRICE));
    hold_done_c = (cnt == CNT_W'(DISP_CYCLES - 1));
  end

  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      state    <= IDLE;
      credit   <= '0;
      change   <= '0;
      dispense <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          // cancel outranks coins, but only means something once credit exists
          if (cancel_ev && (state == COLLECT)) begin
            state  <= REFUND;
            change <= credit;
            credit <= '0;
            busy   <= 1'b1;
            cnt    <= '0;
          end else if (coin_ev_c) begin
            if (paid_c) begin
              state    <= VEND;
              change   <= over_c;
              credit   <= '0;
              dispense <= 1'b1;
              busy     <= 1'b1;
              cnt      <= '0;
            end else begin
              state  <= COLLECT;
              credit <= CREDIT_W'(sum_c);
            end
          end
        end
        VEND, REFUND: begin
          // buttons are ignored here; coins inserted during the hold are lost
          if (hold_done_c) begin
            state    <= IDLE;
            change   <= '0;
            dispense <= 1'b0;
            busy     <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          credit   <= '0;
          change   <= '0;
          dispense <= 1'b0;
          busy     <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Directed bench for vend_credit_fsm with PRICE=75, CREDIT_W=8, DISP_CYCLES=4.
module tb_vend_credit_fsm;

  logic       clk;
  logic       rst_n;
  logic       nickel, dime, quarter, cancel;
  logic [7:0] credit;
  logic       dispense;
  logic [7:0] change;
  logic       busy;

  int checks;
  int errors;

  vend_credit_fsm #(
    .PRICE      (75),
    .CREDIT_W   (8),
    .DISP_CYCLES(4)
  ) dut (
    .CLK50M  (clk),
    .RSTb    (rst_n),
    .nickel  (nickel),
    .dime    (dime),
    .quarter (quarter),
    .cancel  (cancel),
    .credit  (credit),
    .dispense(dispense),
    .change  (change),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of sequence, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic release_all();
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0;
  endtask

  task automatic press_q();
    quarter = 1'b1; repeat (3) tick(); quarter = 1'b0; tick();
  endtask

  // Caller raises the final button; expects a 4-cycle hold then return to IDLE.
  task automatic hold_phase(input string tag, input logic exp_disp, input int exp_chg);
    for (int i = 0; i < 4; i++) begin
      tick();
      check({tag, "_disp"}, 32'(dispense), 32'(exp_disp));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_chg"}, 32'(change), 32'(exp_chg));
      check({tag, "_cred"}, 32'(credit), 32'd0);
      if (i == 2) release_all();
    end
    tick();
    check({tag, "_end_disp"}, 32'(dispense), 32'd0);
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_chg"}, 32'(change), 32'd0);
    check({tag, "_end_cred"}, 32'(credit), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    release_all();
    repeat (3) tick();
    check("rst_credit", 32'(credit), 32'd0);
    check("rst_disp", 32'(dispense), 32'd0);
    check("rst_change", 32'(change), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // exact price
    press_q(); check("exact_c25", 32'(credit), 32'd25);
    press_q(); check("exact_c50", 32'(credit), 32'd50);
    quarter = 1'b1;
    hold_phase("exact", 1'b1, 0);

    // overpay
    dime = 1'b1; repeat (3) tick(); dime = 1'b0; tick();
    check("over_c10", 32'(credit), 32'd10);
    press_q(); check("over_c35", 32'(credit), 32'd35);
    press_q(); check("over_c60", 32'(credit), 32'd60);
    quarter = 1'b1;
    hold_phase("over", 1'b1, 10);

    // cancel with credit, then cancel in IDLE
    nickel = 1'b1; repeat (3) tick(); nickel = 1'b0; tick();
    check("cancel_c5", 32'(credit), 32'd5);
    cancel = 1'b1;
    hold_phase("refund", 1'b0, 5);
    cancel = 1'b1; tick();
    check("idle_cancel_busy", 32'(busy), 32'd0);
    check("idle_cancel_chg", 32'(change), 32'd0);
    cancel = 1'b0; tick();
    check("idle_cancel_cred", 32'(credit), 32'd0);

    // held quarter gives one event
    quarter = 1'b1; repeat (20) tick(); quarter = 1'b0; tick();
    check("held_q", 32'(credit), 32'd25);
    // quarter and dime together: quarter wins
    quarter = 1'b1; dime = 1'b1; tick();
    check("simul_qd", 32'(credit), 32'd50);
    release_all(); tick();
    check("simul_qd_after", 32'(credit), 32'd50);
    // cancel and quarter together in COLLECT: refund of prior credit
    cancel = 1'b1; quarter = 1'b1;
    hold_phase("cq", 1'b0, 50);

    // coin during VEND is lost
    press_q(); press_q();
    quarter = 1'b1; tick();
    check("lock_disp0", 32'(dispense), 32'd1);
    quarter = 1'b0; tick();
    quarter = 1'b1; tick();
    check("lock_disp2", 32'(dispense), 32'd1);
    quarter = 1'b0; tick();
    check("lock_disp3", 32'(dispense), 32'd1);
    tick();
    check("lock_end_disp", 32'(dispense), 32'd0);
    check("lock_cred", 32'(credit), 32'd0);
    check("lock_busy", 32'(busy), 32'd0);

    // quarter held across reset release
    quarter = 1'b1;
    rst_n = 1'b0; repeat (2) tick();
    rst_n = 1'b1; repeat (3) tick();
    check("relq_cred", 32'(credit), 32'd0);
    quarter = 1'b0; tick();
    check("relq_cred2", 32'(credit), 32'd0);
    check("relq_busy", 32'(busy), 32'd0);

    // async reset between edges during VEND
    tick();
    press_q(); press_q();
    quarter = 1'b1; tick();
    check("async_pre_disp", 32'(dispense), 32'd1);
    quarter = 1'b0; tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_disp", 32'(dispense), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_chg", 32'(change), 32'd0);
    check("async_cred", 32'(credit), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    nickel = 1'b1; tick();
    check("post_rst_nickel", 32'(credit), 32'd5);
    nickel = 1'b0; tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
